// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM encoding and
// default sequential PC increment.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_INCR_DEFAULT = 32'd4;

    // Branch/jump targets are forced onto a word boundary.
    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_chk.sv
// Property checker for the fetch stage: IF/ID strobes exclusive, and the icache
// address held while a request is outstanding.
module fetch_unit_chk (
    input logic        CLK,
    input logic        nRST,
    input logic        imemREN,
    input logic        ihit,
    input logic [31:0] imemaddr,
    input logic        fd_enable,
    input logic        fd_flush
);

    a_strobe_excl: assert property (@(posedge CLK) disable iff (!nRST)
        !(fd_enable && fd_flush));

    a_addr_stable: assert property (@(posedge CLK) disable iff (!nRST)
        (imemREN && !ihit) |=> $stable(imemaddr));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the icache request and the write
// side of the IF/ID latch, handling stall, redirect and halt.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter word_t PC_INCR = PC_INCR_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        fd_enable,
    output logic        fd_flush,
    output logic [31:0] fd_imemaddr,
    output logic [31:0] fd_imemload,
    output logic [31:0] fd_next_addr
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_q, pend_d;
    word_t        target_s;

    assign target_s = word_align(redirect_addr);

    // State, PC and pending-redirect registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            pend_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state, next-PC and pending-target selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            FETCH: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (redirect) begin
                    // A miss in flight must complete before the PC may move.
                    if (ihit || !imemREN) begin
                        pc_d = target_s;
                    end else begin
                        pend_d  = target_s;
                        state_d = SQUASH;
                    end
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (ihit) begin
                    pc_d = pc_q + PC_INCR;
                end else begin
                    pc_d = pc_q;
                end
            end
            SQUASH: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    if (redirect) begin
                        pend_d = target_s;
                    end else begin
                        pend_d = pend_q;
                    end
                    if (ihit) begin
                        pc_d    = redirect ? target_s : pend_q;
                        state_d = FETCH;
                    end else begin
                        pc_d = pc_q;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Icache request and IF/ID strobes.
    always_comb begin
        imemREN   = 1'b0;
        fd_enable = 1'b0;
        fd_flush  = 1'b0;
        case (state_q)
            FETCH: begin
                imemREN = 1'b1;
                if (halt || redirect) begin
                    fd_flush = 1'b1;
                end else begin
                    fd_enable = ihit && !stall;
                end
            end
            SQUASH: begin
                imemREN = 1'b1;
            end
            HALTED: begin
                imemREN = 1'b0;
            end
            default: begin
                imemREN = 1'b0;
            end
        endcase
    end

    assign imemaddr     = pc_q;
    assign fd_imemaddr  = pc_q;
    assign fd_imemload  = imemload;
    assign fd_next_addr = pc_q + PC_INCR;

    fetch_unit_chk u_chk (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .ihit      (ihit),
        .imemaddr  (imemaddr),
        .fd_enable (fd_enable),
        .fd_flush  (fd_flush)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a behavioural model of the fetch rules.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        halt = 1'b0;
    logic        imemREN, fd_enable, fd_flush;
    logic [31:0] imemaddr, fd_imemaddr, fd_imemload, fd_next_addr;

    int checks = 0;
    int errors = 0;

    // Behavioural model: where the PC is, whether a dropped fetch is outstanding,
    // where it will go afterwards, and whether the core has stopped.
    logic [31:0] m_pc, m_pend;
    bit          m_halted, m_squash;

    fetch_unit #(.PC_INIT(32'h0000_0000), .PC_INCR(32'd4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
        .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr), .fd_enable(fd_enable),
        .fd_flush(fd_flush), .fd_imemaddr(fd_imemaddr), .fd_imemload(fd_imemload),
        .fd_next_addr(fd_next_addr)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 32'h0; m_halted = 1'b0; m_squash = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        tgt = redirect_addr & 32'hFFFF_FFFC;
        if (m_halted) begin
            // frozen until reset
        end else if (m_squash) begin
            if (halt) m_halted = 1'b1;
            else begin
                if (redirect) m_pend = tgt;
                if (ihit) begin m_pc = m_pend; m_squash = 1'b0; end
            end
        end else if (halt) m_halted = 1'b1;
        else if (redirect) begin
            if (ihit) m_pc = tgt;
            else begin m_pend = tgt; m_squash = 1'b1; end
        end else if (!stall && ihit) m_pc = m_pc + 32'd4;
    endtask

    // Called just after a falling edge; inputs settle 1 time unit later.
    task automatic drive(input bit h, input logic [31:0] ld, input bit st,
                         input bit rd, input logic [31:0] ra, input bit hl);
        ihit = h; imemload = ld; stall = st; redirect = rd; redirect_addr = ra; halt = hl;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (nRST) model_edge();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRST = 1'b0;
        model_reset();
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imemaddr); end
        checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL reset_ren: got %b want 1", imemREN); end
        checks++; if (fd_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", fd_flush); end
        checks++; if (fd_enable !== 1'b1) begin errors++; $display("FAIL reset_en_hit: got %b want 1", fd_enable); end
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (fd_enable !== 1'b0) begin errors++; $display("FAIL reset_en_stall: got %b want 0", fd_enable); end
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] ld;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ld = $urandom;
            drive(1'b1, ld, 1'b0, 1'b0, 32'h0, 1'b0);
            checks++; if (fd_enable !== 1'b1) begin errors++; $display("FAIL seq_en[%0d]: got %b want 1", i, fd_enable); end
            checks++; if (fd_imemaddr !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, fd_imemaddr, 32'(i * 4)); end
            checks++; if (fd_next_addr !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_next[%0d]: got %h want %h", i, fd_next_addr, 32'(i * 4 + 4)); end
            checks++; if (fd_imemload !== ld) begin errors++; $display("FAIL seq_load[%0d]: got %h want %h", i, fd_imemload, ld); end
            tick();
        end
        checks++; if (imemaddr !== 32'hC) begin errors++; $display("FAIL seq_final_pc: got %h want 0000000c", imemaddr); end
    endtask

    task automatic test_stall();
        do_reset();
        hits(2);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 1'b1, 1'b0, 32'h0, 1'b0);
            checks++; if (fd_enable !== 1'b0) begin errors++; $display("FAIL stall_en[%0d]: got %b want 0", i, fd_enable); end
            checks++; if (imemaddr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 00000008", i, imemaddr); end
            tick();
        end
        drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (fd_enable !== 1'b1) begin errors++; $display("FAIL stall_release_en: got %b want 1", fd_enable); end
        tick();
        checks++; if (imemaddr !== 32'hC) begin errors++; $display("FAIL stall_after_pc: got %h want 0000000c", imemaddr); end
    endtask

    task automatic test_redirect_hit();
        do_reset();
        hits(4);
        drive(1'b1, $urandom, 1'b0, 1'b1, 32'h43, 1'b0);
        checks++; if (fd_flush !== 1'b1) begin errors++; $display("FAIL redir_flush: got %b want 1", fd_flush); end
        checks++; if (fd_enable !== 1'b0) begin errors++; $display("FAIL redir_en: got %b want 0", fd_enable); end
        tick();
        checks++; if (imemaddr !== 32'h40) begin errors++; $display("FAIL redir_target: got %h want 00000040", imemaddr); end
    endtask

    task automatic test_squash();
        do_reset();
        hits(8);
        drive(1'b0, $urandom, 1'b0, 1'b1, 32'h80, 1'b0);
        checks++; if (fd_flush !== 1'b1) begin errors++; $display("FAIL squash_flush: got %b want 1", fd_flush); end
        tick();
        drive(1'b0, $urandom, 1'b0, 1'b1, 32'h90, 1'b0);
        checks++; if (imemaddr !== 32'h20) begin errors++; $display("FAIL squash_hold: got %h want 00000020", imemaddr); end
        checks++; if (fd_enable !== 1'b0) begin errors++; $display("FAIL squash_en0: got %b want 0", fd_enable); end
        tick();
        drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (fd_enable !== 1'b0) begin errors++; $display("FAIL squash_drop_en: got %b want 0", fd_enable); end
        checks++; if (fd_flush !== 1'b0) begin errors++; $display("FAIL squash_drop_flush: got %b want 0", fd_flush); end
        tick();
        checks++; if (imemaddr !== 32'h90) begin errors++; $display("FAIL squash_latest: got %h want 00000090", imemaddr); end
        drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (fd_enable !== 1'b1) begin errors++; $display("FAIL squash_resume_en: got %b want 1", fd_enable); end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        hits(3);
        drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++; if (fd_flush !== 1'b1) begin errors++; $display("FAIL halt_flush: got %b want 1", fd_flush); end
        checks++; if (fd_enable !== 1'b0) begin errors++; $display("FAIL halt_en: got %b want 0", fd_enable); end
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            checks++; if ({imemREN, fd_enable, fd_flush} !== 3'b000) begin errors++; $display("FAIL halted_strobes[%0d]: got %b want 000", i, {imemREN, fd_enable, fd_flush}); end
            checks++; if (imemaddr !== 32'hC) begin errors++; $display("FAIL halted_pc[%0d]: got %h want 0000000c", i, imemaddr); end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        nRST = 1'b0;
        #1;
        checks++; if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin errors++; $display("FAIL halt_reset: got addr %h ren %b want 00000000 1", imemaddr, imemREN); end
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset_squash();
        do_reset();
        hits(1);
        drive(1'b0, $urandom, 1'b0, 1'b1, 32'h80, 1'b0);
        tick();
        drive(1'b0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        nRST = 1'b0;
        #1;
        checks++; if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin errors++; $display("FAIL sq_reset_now: got addr %h ren %b want 00000000 1", imemaddr, imemREN); end
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (fd_enable !== 1'b1) begin errors++; $display("FAIL sq_reset_en: got %b want 1", fd_enable); end
        tick();
        checks++; if (imemaddr !== 32'h4) begin errors++; $display("FAIL sq_reset_nopend: got %h want 00000004", imemaddr); end
    endtask

    task automatic test_random();
        int halted_cycles;
        bit e_en, e_fl;
        do_reset();
        halted_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_halted && halted_cycles > 6) begin
                do_reset();
                halted_cycles = 0;
            end
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 63) == 0);
            e_en = !m_halted && !m_squash && ihit && !stall && !redirect && !halt;
            e_fl = !m_halted && !m_squash && (halt || redirect);
            checks++;
            if ({imemREN, fd_enable, fd_flush} !== {!m_halted, e_en, e_fl}) begin
                errors++;
                $display("FAIL rnd_strobes[%0d]: got %b want %b", i, {imemREN, fd_enable, fd_flush}, {!m_halted, e_en, e_fl});
            end
            checks++;
            if (imemaddr !== m_pc || fd_imemaddr !== m_pc || fd_next_addr !== m_pc + 32'd4 || fd_imemload !== imemload) begin
                errors++;
                $display("FAIL rnd_data[%0d]: got pc %h/%h next %h load %h want pc %h next %h load %h",
                         i, imemaddr, fd_imemaddr, fd_next_addr, fd_imemload, m_pc, m_pc + 32'd4, imemload);
            end
            if (m_halted) halted_cycles++;
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_hit();
        test_squash();
        test_halt();
        test_reset_squash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
